// File: rtl/adc_serial_responder.sv
// Slave-side stand-in for a 12-bit serial ADC: decodes the master's command frame,
// shifts out the previous result and emulates conversion timing on eoc.
module adc_serial_responder #(
  parameter int DATA_W      = 12,
  parameter int CONV_CYCLES = 125,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_cs,
  input  logic              ioclk,
  input  logic              din,
  output logic              dout,
  output logic              eoc,
  output logic [3:0]        ch_sel,
  input  logic [DATA_W-1:0] sample_in,
  output logic              frame_err
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CONV, WAIT_CS} state_t;

  // Each stage holds {din, ioclk, adc_cs}; chip select resets high so no false edge.
  logic [2:0] sync_reg [SYNC_STAGES];

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 3'b001;
          else     sync_reg[gi] <= {din, ioclk, adc_cs};
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 3'b001;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic cs_s, io_s, din_s;
  logic cs_dly_reg, io_dly_reg;
  logic cs_fall, cs_rise, io_rise, io_fall;

  assign cs_s  = sync_reg[SYNC_STAGES-1][0];
  assign io_s  = sync_reg[SYNC_STAGES-1][1];
  assign din_s = sync_reg[SYNC_STAGES-1][2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_dly_reg <= 1'b1;
      io_dly_reg <= 1'b0;
    end else begin
      cs_dly_reg <= cs_s;
      io_dly_reg <= io_s;
    end
  end

  assign cs_fall = cs_dly_reg & ~cs_s;
  assign cs_rise = ~cs_dly_reg & cs_s;
  assign io_rise = ~io_dly_reg & io_s;
  assign io_fall = io_dly_reg & ~io_s;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   cmd_reg, cmd_next;
  logic [DATA_W-1:0]   out_reg, out_next;
  logic [DATA_W-1:0]   result_reg, result_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [CONV_W-1:0]   conv_cnt_reg, conv_cnt_next;
  logic                eoc_reg, eoc_next;
  logic [3:0]          ch_sel_reg, ch_sel_next;
  logic                frame_err_reg, frame_err_next;
  logic [3:0]          addr;

  assign addr = cmd_reg[DATA_W-1 -: 4];

  always_comb begin
    state_next     = state_reg;
    cmd_next       = cmd_reg;
    out_next       = out_reg;
    result_next    = result_reg;
    bit_cnt_next   = bit_cnt_reg;
    conv_cnt_next  = conv_cnt_reg;
    eoc_next       = eoc_reg;
    ch_sel_next    = ch_sel_reg;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        eoc_next = 1'b1;
        out_next = '0;
        if (cs_fall) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          out_next     = result_reg;
        end
      end
      SHIFT: begin
        if (io_rise) cmd_next = {cmd_reg[DATA_W-2:0], din_s};
        // A completing falling edge wins over a simultaneous chip-select release.
        if (io_fall && bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
          out_next     = '0;
          bit_cnt_next = CNT_W'(DATA_W);
          if (addr == 4'b1110) begin
            state_next = WAIT_CS;
          end else if (addr == 4'b1111) begin
            frame_err_next = 1'b1;
            state_next     = WAIT_CS;
          end else begin
            ch_sel_next   = addr;
            state_next    = CONV;
            eoc_next      = 1'b0;
            conv_cnt_next = '0;
          end
        end else if (cs_rise) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
          out_next       = '0;
        end else if (io_fall) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          out_next     = {out_reg[DATA_W-2:0], 1'b0};
        end
      end
      CONV: begin
        if (cs_fall) frame_err_next = 1'b1;
        if (conv_cnt_reg == CONV_W'(CONV_CYCLES - 1)) begin
          // ch_sel still holds the decoded address, so it selects the result source.
          case (ch_sel_reg)
            4'b1011: result_next = {1'b1, {(DATA_W-1){1'b0}}};
            4'b1100: result_next = '0;
            4'b1101: result_next = '1;
            default: result_next = sample_in;
          endcase
          eoc_next   = 1'b1;
          state_next = cs_s ? IDLE : WAIT_CS;
        end else begin
          conv_cnt_next = conv_cnt_reg + 1'b1;
        end
      end
      WAIT_CS: begin
        eoc_next = 1'b1;
        out_next = '0;
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      out_reg       <= '0;
      result_reg    <= '0;
      bit_cnt_reg   <= '0;
      conv_cnt_reg  <= '0;
      eoc_reg       <= 1'b1;
      ch_sel_reg    <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_reg       <= cmd_next;
      out_reg       <= out_next;
      result_reg    <= result_next;
      bit_cnt_reg   <= bit_cnt_next;
      conv_cnt_reg  <= conv_cnt_next;
      eoc_reg       <= eoc_next;
      ch_sel_reg    <= ch_sel_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign dout      = out_reg[DATA_W-1];
  assign eoc       = eoc_reg;
  assign ch_sel    = ch_sel_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: drives master-side frames with a 400 ns ioclk
// and checks read-back data, eoc timing, channel select and frame_err pulses.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_cs;
  logic        ioclk;
  logic        din;
  logic        dout;
  logic        eoc;
  logic [3:0]  ch_sel;
  logic [11:0] sample_in;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int eoc_low_cnt = 0;

  adc_serial_responder #(.DATA_W(12), .CONV_CYCLES(125), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .adc_cs(adc_cs), .ioclk(ioclk), .din(din),
    .dout(dout), .eoc(eoc), .ch_sel(ch_sel), .sample_in(sample_in), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (eoc === 1'b0) eoc_low_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drops adc_cs and clocks nbits command bits; the final falling edge is left untimed.
  task automatic shift_bits(input logic [11:0] cmd, input int nbits, output logic [11:0] rd);
    rd = '0;
    adc_cs = 1'b0;
    tick(10);
    for (int i = 0; i < nbits; i++) begin
      rd[11-i] = dout;
      din = cmd[11-i];
      ioclk = 1'b1;
      tick(10);
      ioclk = 1'b0;
      if (i < nbits - 1) tick(10);
    end
  endtask

  task automatic wait_fall(output int dly);
    dly = 0;
    while (eoc === 1'b1 && dly < 20) begin
      tick(1);
      dly++;
    end
  endtask

  task automatic wait_rise(output int len);
    len = 0;
    while (eoc === 1'b0 && len < 500) begin
      tick(1);
      len++;
    end
  endtask

  task automatic end_frame();
    adc_cs = 1'b1;
    tick(10);
  endtask

  logic [11:0] rd;
  int dly, len, e0, l0;

  initial begin
    rst = 1'b1; adc_cs = 1'b1; ioclk = 1'b0; din = 1'b0; sample_in = 12'h000;

    // 1. reset with ioclk toggling
    for (int i = 0; i < 3; i++) begin
      ioclk = ~ioclk;
      tick(1);
      chk("rst_eoc", 32'(eoc), 32'h1);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_ch_sel", 32'(ch_sel), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
    end
    ioclk = 1'b0;
    rst = 1'b0;
    tick(5);
    e0 = err_cnt;

    // 2. channel 3 conversion
    sample_in = 12'hA5C;
    shift_bits(12'h300, 12, rd);
    chk("ch3_read_reset_result", 32'(rd), 32'h000);
    wait_fall(dly);
    chk("ch3_eoc_fall_delay", 32'(dly), 32'd3);
    chk("ch3_ch_sel", 32'(ch_sel), 32'h3);
    wait_rise(len);
    chk("ch3_eoc_low_len", 32'(len), 32'd125);
    end_frame();

    // 3. forced test addresses
    shift_bits(12'hB00, 12, rd);
    chk("read_after_ch3", 32'(rd), 32'hA5C);
    sample_in = 12'h123;
    wait_fall(dly);
    wait_rise(len);
    chk("addr1011_eoc_low_len", 32'(len), 32'd125);
    chk("addr1011_ch_sel", 32'(ch_sel), 32'hB);
    end_frame();
    shift_bits(12'hD00, 12, rd);
    chk("read_after_1011", 32'(rd), 32'h800);
    wait_fall(dly);
    wait_rise(len);
    end_frame();
    shift_bits(12'hC00, 12, rd);
    chk("read_after_1101", 32'(rd), 32'hFFF);
    wait_fall(dly);
    wait_rise(len);
    chk("addr1100_ch_sel", 32'(ch_sel), 32'hC);
    end_frame();
    chk("no_err_so_far", 32'(err_cnt - e0), 32'd0);

    // 4. abort after 7 ioclk cycles
    e0 = err_cnt; l0 = eoc_low_cnt;
    shift_bits(12'h500, 7, rd);
    chk("partial_read_after_1100", 32'(rd), 32'h000);
    tick(10);
    end_frame();
    chk("abort_frame_err", 32'(err_cnt - e0), 32'd1);
    chk("abort_no_conv", 32'(eoc_low_cnt - l0), 32'd0);
    chk("abort_ch_sel_kept", 32'(ch_sel), 32'hC);

    // 5. power-down then reserved
    e0 = err_cnt; l0 = eoc_low_cnt;
    shift_bits(12'hE00, 12, rd);
    chk("read_after_abort", 32'(rd), 32'h000);
    tick(20);
    chk("pdown_no_err", 32'(err_cnt - e0), 32'd0);
    chk("pdown_eoc_high", 32'(eoc_low_cnt - l0), 32'd0);
    chk("pdown_ch_sel_kept", 32'(ch_sel), 32'hC);
    end_frame();
    shift_bits(12'hF00, 12, rd);
    chk("read_after_pdown", 32'(rd), 32'h000);
    tick(20);
    end_frame();
    chk("reserved_frame_err", 32'(err_cnt - e0), 32'd1);
    chk("reserved_eoc_high", 32'(eoc_low_cnt - l0), 32'd0);
    shift_bits(12'h700, 12, rd);
    chk("read_after_reserved", 32'(rd), 32'h000);
    wait_fall(dly);
    wait_rise(len);
    chk("ch7_ch_sel", 32'(ch_sel), 32'h7);
    end_frame();

    // 6. reset 40 clk into a conversion
    sample_in = 12'h456;
    shift_bits(12'h200, 12, rd);
    chk("read_after_ch7", 32'(rd), 32'h123);
    wait_fall(dly);
    chk("ch2_eoc_fall_delay", 32'(dly), 32'd3);
    tick(40);
    chk("ch2_eoc_low_mid", 32'(eoc), 32'h0);
    rst = 1'b1; adc_cs = 1'b1;
    tick(1);
    chk("midrst_eoc", 32'(eoc), 32'h1);
    chk("midrst_ch_sel", 32'(ch_sel), 32'h0);
    chk("midrst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    tick(10);
    shift_bits(12'h100, 12, rd);
    chk("read_after_midrst", 32'(rd), 32'h000);
    wait_fall(dly);
    wait_rise(len);
    chk("ch1_eoc_low_len", 32'(len), 32'd125);
    end_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Synthesizable slave-side model of the 12-bit serial ADC (TLC2543-style) that the system top drives over adc_cs/ioclk/din, answering on dout/eoc.
- Lets the acquisition path and training loop be exercised on hardware or in simulation without a real converter.
- Per-channel sample values come from a parallel port.
- Sits opposite the system top's ADC master interface, one instance per converter.

Parameters:
- DATA_W, 12: conversion and command frame width in bits.
- CONV_CYCLES, 125: clk cycles eoc is held low per conversion (2.5 us at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on adc_cs, ioclk and din.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- adc_cs  input  1  chip select from master, active low.
- ioclk  input  1  serial I/O clock from master, asynchronous to clk.
- din  input  1  command bits from master, MSB first.
- dout  output  1  previous conversion result, MSB first.
- eoc  output  1  end of conversion; low while converting.
- ch_sel  output  4  channel address of the conversion in progress or last completed.
- sample_in  input  DATA_W  analog value for ch_sel; sampled at end of conversion.
- frame_err  output  1  one-clk pulse on a protocol violation.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs take their reset values on that edge, including mid-frame or mid-conversion. Any in-flight conversion is dropped.
  - dout=0, eoc=1, ch_sel=0, frame_err=0.
  - result register=0, command shift register=0, bit counter=0, state=IDLE.
- Input synchronization: adc_cs, ioclk and din each pass through SYNC_STAGES flops. Edges are detected between the last sync stage and one extra delay flop.
  - An ioclk edge is acted on SYNC_STAGES+1 clk after it reaches the pin.
  - The master must keep ioclk high and low for >= 4 clk each.
- State IDLE:
  - eoc=1, dout=0.
  - adc_cs falling edge -> SHIFT, bit counter=0, dout=result[DATA_W-1] on the next clk.
- State SHIFT:
  - ioclk rising edge: cmd <= {cmd[DATA_W-2:0], din_sync}.
  - ioclk falling edge: bit counter+1; dout shifts to the next lower result bit. After the last bit, dout=0.
  - On the DATA_W-th falling edge, decode cmd[DATA_W-1:DATA_W-4] as addr:
    - addr 0000..1010: ch_sel<=addr, go to CONV.
    - addr 1011: ch_sel<=addr, go to CONV, result forced to 12'h800.
    - addr 1100: ch_sel<=addr, go to CONV, result forced to 12'h000.
    - addr 1101: ch_sel<=addr, go to CONV, result forced to 12'hFFF.
    - addr 1110: power-down; no conversion, eoc stays 1, result unchanged, go to WAIT_CS.
    - addr 1111: reserved; frame_err pulse, go to WAIT_CS.
  - On CONV entry, eoc goes 0 on the clk after the decoding edge.
  - adc_cs rising before DATA_W falling edges: abort. frame_err pulse, return to IDLE, no conversion, result and ch_sel unchanged.
- State CONV:
  - eoc=0 for exactly CONV_CYCLES clk.
  - On the final cycle, result <= sample_in (or the forced value for addr 1011-1101); eoc returns to 1 on the next clk.
  - Then go to IDLE if adc_cs is high, else WAIT_CS.
  - ioclk edges during CONV are ignored.
  - adc_cs falling during CONV: frame_err pulse, ignored.
- State WAIT_CS: eoc=1, dout=0; wait for adc_cs high, then go to IDLE.
- Simultaneous events:
  - adc_cs rising in the same clk as the DATA_W-th falling ioclk edge: the frame completes and the conversion starts.
  - rst has priority over all events.

Test Plan:
1. Reset: hold rst=1 for 3 clk with ioclk toggling -> eoc=1, dout=0, ch_sel=0, frame_err=0 throughout.
2. Channel 3 conversion: frame cmd=12'h300, sample_in=12'hA5C, ioclk period 400 ns.
   - eoc falls 1 clk after the 12th falling-edge detection and stays low exactly 125 clk; ch_sel=3.
   - The next frame's dout bits are 1010_0101_1100.
3. Test addresses: cmd addr 1011, then 1101, then 1100.
   - Successive following frames read 12'h800, 12'hFFF, 12'h000, regardless of sample_in.
4. Abort: raise adc_cs after 7 ioclk cycles -> frame_err pulses once, eoc never goes low, the next frame still returns the previous result.
5. Power-down/reserved: addr 1110 -> eoc stays 1, no frame_err. addr 1111 -> one frame_err pulse. Result unchanged in both cases.
6. Reset mid-conversion: assert rst 40 clk into CONV -> eoc=1 on the next clk, and a following frame reads 12'h000.
